// File: rtl/gb_instr_issuer.sv
// gb_instr_issuer: FIFO-buffered opcode source for the gbprocessor; issues one opcode per
// GAP+2 cycles and returns the sampled probe. Define GB_ISSUE_STATS_EN for issue/drop counters.
module gb_instr_issuer #(
  parameter int INSTR_W = 8,
  parameter int PROBE_W = 8,
  parameter int DEPTH   = 8,
  parameter int GAP     = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [INSTR_W-1:0] host_instr,
  input  logic               host_push,
  output logic               host_full,
  output logic               host_empty,
  output logic               overflow,
  output logic [INSTR_W-1:0] instruction,
  output logic               valid,
  input  logic [PROBE_W-1:0] probe,
  output logic [PROBE_W-1:0] result,
  output logic               result_valid,
`ifdef GB_ISSUE_STATS_EN
  output logic [15:0]        issued_count,
  output logic [7:0]         dropped_count,
`endif
  output logic               busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic               full_q;
  logic               empty_q;
  logic               overflow_q;
  logic               push_ok;
  logic               push_rej;
  logic               pop;

  state_t             state_q;
  logic [GAP_W-1:0]   gap_q;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;
  logic [PROBE_W-1:0] result_q;
  logic               result_valid_q;
  logic               busy_q;

  // A full FIFO rejects the push even if the head is popped in the same cycle.
  always_comb begin
    push_ok  = host_push && !full_q;
    push_rej = host_push && full_q;
    pop      = (state_q == IDLE) && enable && !empty_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
      if (push_rej) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= host_instr;
  end

  // Issue FSM: IDLE pops, ISSUE holds the one-cycle strobe, WAIT counts GAP cycles to a stable probe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      gap_q          <= '0;
      instr_q        <= '0;
      valid_q        <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            instr_q <= mem_q[rd_ptr_q];
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          valid_q <= 1'b0;
          gap_q   <= GAP_W'(GAP - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (gap_q == '0) begin
            result_q       <= probe;
            result_valid_q <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef GB_ISSUE_STATS_EN
  logic [15:0] issued_q;
  logic [7:0]  dropped_q;

  // Issue count wraps; drop count saturates so a flood of rejects stays visible.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      issued_q  <= '0;
      dropped_q <= '0;
    end else begin
      if (pop) issued_q <= issued_q + 16'd1;
      if (push_rej && (dropped_q != 8'hFF)) dropped_q <= dropped_q + 8'd1;
    end
  end

  assign issued_count  = issued_q;
  assign dropped_count = dropped_q;
`endif

  assign host_full    = full_q;
  assign host_empty   = empty_q;
  assign overflow     = overflow_q;
  assign instruction  = instr_q;
  assign valid        = valid_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_gb_instr_issuer.sv
// tb_gb_instr_issuer: directed checks of gb_instr_issuer (DEPTH=8, GAP=4) with
// hand-computed expected values and immediate assertions.
module tb_gb_instr_issuer;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [7:0] host_instr;
  logic       host_push;
  logic       host_full;
  logic       host_empty;
  logic       overflow;
  logic [7:0] instruction;
  logic       valid;
  logic [7:0] probe;
  logic [7:0] result;
  logic       result_valid;
  logic       busy;
`ifdef GB_ISSUE_STATS_EN
  logic [15:0] issued_count;
  logic [7:0]  dropped_count;
`endif

  int compared   = 0;
  int mismatched = 0;
  int validCycles  = 0;
  int resultCycles = 0;
  int v0;
  int r0;
  int n;

  gb_instr_issuer #(
    .INSTR_W(8),
    .PROBE_W(8),
    .DEPTH(8),
    .GAP(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .host_instr(host_instr),
    .host_push(host_push),
    .host_full(host_full),
    .host_empty(host_empty),
    .overflow(overflow),
    .instruction(instruction),
    .valid(valid),
    .probe(probe),
    .result(result),
    .result_valid(result_valid),
`ifdef GB_ISSUE_STATS_EN
    .issued_count(issued_count),
    .dropped_count(dropped_count),
`endif
    .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Strobe widths are measured mid-cycle so a stuck-high strobe shows up as extra cycles.
  always @(negedge clock) begin
    if (valid) validCycles <= validCycles + 1;
    if (result_valid) resultCycles <= resultCycles + 1;
  end

  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitForValid(input int limit, output int cycles);
    cycles = 0;
    do begin
      tick(1);
      cycles++;
    end while (!valid && cycles < limit);
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    host_push = 1'b0;
    host_instr = 8'h00;
    probe = 8'h00;
    #2 reset = 1'b0;
    tick(3);

    // Reset state
    checkOutput("rst_instruction", 32'(instruction), 32'h00);
    checkOutput("rst_valid", 32'(valid), 32'h0);
    checkOutput("rst_result", 32'(result), 32'h00);
    checkOutput("rst_result_valid", 32'(result_valid), 32'h0);
    checkOutput("rst_overflow", 32'(overflow), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_host_empty", 32'(host_empty), 32'h1);
    checkOutput("rst_host_full", 32'(host_full), 32'h0);
    reset = 1'b1;
    tick(1);

    // Single issue
    $display("[TB] single issue");
    enable = 1'b1;
    probe = 8'hA5;
    host_instr = 8'h3C;
    host_push = 1'b1;
    v0 = validCycles;
    tick(1);
    host_push = 1'b0;
    checkOutput("t1_valid_early", 32'(valid), 32'h0);
    checkOutput("t1_not_empty", 32'(host_empty), 32'h0);
    tick(1);
    checkOutput("t1_valid", 32'(valid), 32'h1);
    checkOutput("t1_instruction", 32'(instruction), 32'h3C);
    checkOutput("t1_busy", 32'(busy), 32'h1);
    tick(1);
    checkOutput("t1_valid_drop", 32'(valid), 32'h0);
    tick(3);
    checkOutput("t1_result_valid_early", 32'(result_valid), 32'h0);
    tick(1);
    checkOutput("t1_result_valid", 32'(result_valid), 32'h1);
    checkOutput("t1_result", 32'(result), 32'hA5);
    tick(1);
    checkOutput("t1_result_valid_drop", 32'(result_valid), 32'h0);
    checkOutput("t1_busy_after", 32'(busy), 32'h0);
    checkOutput("t1_instruction_hold", 32'(instruction), 32'h3C);
    checkOutput("t1_valid_width", 32'(validCycles - v0), 32'd1);

    // Back-to-back issue with a push and pop in the same cycle
    $display("[TB] back-to-back");
    v0 = validCycles;
    r0 = resultCycles;
    host_instr = 8'h01;
    host_push = 1'b1;
    tick(1);
    host_instr = 8'h02;
    tick(1);
    checkOutput("t2_valid0", 32'(valid), 32'h1);
    checkOutput("t2_instr0", 32'(instruction), 32'h01);
    host_instr = 8'h03;
    tick(1);
    host_push = 1'b0;
    waitForValid(20, n);
    checkOutput("t2_gap1", 32'(n), 32'd5);
    checkOutput("t2_instr1", 32'(instruction), 32'h02);
    waitForValid(20, n);
    checkOutput("t2_gap2", 32'(n), 32'd6);
    checkOutput("t2_instr2", 32'(instruction), 32'h03);
    tick(8);
    checkOutput("t2_results", 32'(resultCycles - r0), 32'd3);
    checkOutput("t2_valids", 32'(validCycles - v0), 32'd3);
    checkOutput("t2_empty", 32'(host_empty), 32'h1);

    // Overflow with issue held off
    $display("[TB] overflow");
    enable = 1'b0;
    for (int i = 0; i < 9; i++) begin
      host_instr = 8'h10 + 8'(i);
      host_push = 1'b1;
      tick(1);
      if (i == 7) begin
        checkOutput("t3_full_at8", 32'(host_full), 32'h1);
        checkOutput("t3_no_overflow_at8", 32'(overflow), 32'h0);
      end
    end
    host_push = 1'b0;
    checkOutput("t3_full_at9", 32'(host_full), 32'h1);
    checkOutput("t3_overflow", 32'(overflow), 32'h1);
    v0 = validCycles;
    enable = 1'b1;
    waitForValid(10, n);
    checkOutput("t3_first_gap", 32'(n), 32'd1);
    checkOutput("t3_instr0", 32'(instruction), 32'h10);
    for (int i = 1; i < 8; i++) begin
      waitForValid(10, n);
      checkOutput("t3_gap", 32'(n), 32'd6);
      checkOutput("t3_instr", 32'(instruction), 32'h10 + 32'(i));
    end
    tick(12);
    checkOutput("t3_issue_total", 32'(validCycles - v0), 32'd8);
    checkOutput("t3_overflow_sticky", 32'(overflow), 32'h1);
    checkOutput("t3_empty", 32'(host_empty), 32'h1);
    checkOutput("t3_not_full", 32'(host_full), 32'h0);

    // Enable dropped mid-WAIT
    $display("[TB] enable gating");
    enable = 1'b0;
    probe = 8'h5A;
    host_instr = 8'hA1;
    host_push = 1'b1;
    tick(1);
    host_instr = 8'hA2;
    tick(1);
    host_push = 1'b0;
    v0 = validCycles;
    enable = 1'b1;
    waitForValid(10, n);
    checkOutput("t4_instr0", 32'(instruction), 32'hA1);
    tick(2);
    enable = 1'b0;
    tick(3);
    checkOutput("t4_result_valid", 32'(result_valid), 32'h1);
    checkOutput("t4_result", 32'(result), 32'h5A);
    tick(6);
    checkOutput("t4_no_second_issue", 32'(validCycles - v0), 32'd1);
    checkOutput("t4_idle", 32'(busy), 32'h0);
    checkOutput("t4_still_queued", 32'(host_empty), 32'h0);
    enable = 1'b1;
    tick(1);
    checkOutput("t4_reissue_valid", 32'(valid), 32'h1);
    checkOutput("t4_instr1", 32'(instruction), 32'hA2);
    tick(8);

    // Reset while WAIT with entries queued
    $display("[TB] reset mid-WAIT");
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      host_instr = 8'hB1 + 8'(i);
      host_push = 1'b1;
      tick(1);
    end
    host_push = 1'b0;
    enable = 1'b1;
    waitForValid(10, n);
    checkOutput("t5_instr0", 32'(instruction), 32'hB1);
    tick(2);
    v0 = validCycles;
    r0 = resultCycles;
    reset = 1'b0;
    #1;
    checkOutput("t5_valid", 32'(valid), 32'h0);
    checkOutput("t5_instruction", 32'(instruction), 32'h00);
    checkOutput("t5_busy", 32'(busy), 32'h0);
    checkOutput("t5_empty", 32'(host_empty), 32'h1);
    checkOutput("t5_full", 32'(host_full), 32'h0);
    checkOutput("t5_overflow", 32'(overflow), 32'h0);
    checkOutput("t5_result", 32'(result), 32'h00);
    checkOutput("t5_result_valid", 32'(result_valid), 32'h0);
    tick(1);
    reset = 1'b1;
    tick(15);
    checkOutput("t5_no_issue", 32'(validCycles - v0), 32'd0);
    checkOutput("t5_no_result", 32'(resultCycles - r0), 32'd0);
    checkOutput("t5_empty_after", 32'(host_empty), 32'h1);
    checkOutput("t5_idle_after", 32'(busy), 32'h0);

    // Streamed pushes wrapping the pointers
    $display("[TB] pointer wrap");
    v0 = validCycles;
    for (int i = 0; i < 20; i++) begin
      host_instr = 8'h40 + 8'(i);
      host_push = 1'b1;
      tick(1);
      host_push = 1'b0;
      tick(1);
      checkOutput("t6_valid", 32'(valid), 32'h1);
      checkOutput("t6_instr", 32'(instruction), 32'h40 + 32'(i));
      tick(4);
    end
    tick(8);
    checkOutput("t6_issue_total", 32'(validCycles - v0), 32'd20);
    checkOutput("t6_empty", 32'(host_empty), 32'h1);
`ifdef GB_ISSUE_STATS_EN
    checkOutput("t6_issued_count", 32'(issued_count), 32'd20);
    checkOutput("t6_dropped_count", 32'(dropped_count), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
